// File: rtl/frame_writer_pkg.sv
// Shared constants and types for the framebuffer writer: screen geometry, word packing and
// the hold-buffer word layout.
package frame_writer_pkg;

  localparam int unsigned SCREEN_W     = 800;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned PIX_PER_WORD = 16;
  localparam int unsigned DATA_WIDTH   = 2 * PIX_PER_WORD;
  localparam int unsigned SLOT_WIDTH   = $clog2(PIX_PER_WORD);
  localparam int unsigned LIN_WIDTH    = $clog2(SCREEN_W * SCREEN_H);
  localparam int unsigned WADDR_WIDTH  = $clog2(SCREEN_W * SCREEN_H / PIX_PER_WORD);

  typedef logic [1:0] palette_t;

  typedef struct packed {
    logic [WADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [PIX_PER_WORD-1:0] mask;
  } fb_word_t;

  typedef enum logic [1:0] {StRun, StDrain, StEmit, StDone} fw_state_e;

endpackage

// File: rtl/frame_writer_fb_coalescer.sv
// Hold buffer that merges pixels landing in the same memory word into one masked write,
// emitting the previous word on eviction or when forced to flush.
module frame_writer_fb_coalescer
  import frame_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic [LIN_WIDTH-1:0] pix_lin,
  input  palette_t             pix_pal,
  input  logic                 force_flush,
  output logic                 emit_valid,
  output fb_word_t             emit_word
);

  fb_word_t                hold_q, hold_d;
  logic [WADDR_WIDTH-1:0]  word;
  logic [SLOT_WIDTH-1:0]   slot;

  always_comb begin
    word       = pix_lin[SLOT_WIDTH +: WADDR_WIDTH];
    slot       = pix_lin[SLOT_WIDTH-1:0];
    hold_d     = hold_q;
    emit_valid = 1'b0;
    emit_word  = hold_q;
    if (force_flush) begin
      emit_valid  = |hold_q.mask;
      hold_d.mask = '0;
    end else if (pix_valid) begin
      if ((|hold_q.mask) && (word == hold_q.addr)) begin
        hold_d.mask[slot]               = 1'b1;
        hold_d.data[{slot, 1'b0} +: 2]  = pix_pal;
      end else begin
        // Unmasked slots are zeroed so the emitted data is deterministic.
        emit_valid                      = |hold_q.mask;
        hold_d.addr                     = word;
        hold_d.mask                     = '0;
        hold_d.mask[slot]               = 1'b1;
        hold_d.data                     = '0;
        hold_d.data[{slot, 1'b0} +: 2]  = pix_pal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Writes the painter's pixel stream into a double-buffered 2-bpp framebuffer with masked
// word writes. Optional FRAME_WRITER_CLIP_EN drops off-screen pixels.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned COOR_WIDTH = 11
) (
  input  logic                    clk_33m,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [COOR_WIDTH-1:0]   in_x,
  input  logic [COOR_WIDTH-1:0]   in_y,
  input  palette_t                in_palette,
  input  logic                    skip_zero,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    front_frame,
  output logic                    mem_we,
  output logic [WADDR_WIDTH:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [PIX_PER_WORD-1:0] mem_wmask
);

  fw_state_e              state_q, state_d;
  logic                   s1_valid_q;
  logic [LIN_WIDTH-1:0]   s1_lin_q, lin;
  palette_t               s1_pal_q;
  logic                   keep, accept, force_flush;
  logic                   front_q, overrun_q;
  logic                   emit_valid;
  fb_word_t               emit_word;
  logic                   mem_we_q;
  logic [WADDR_WIDTH:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic [PIX_PER_WORD-1:0] mem_wmask_q;

  always_comb begin
    lin = LIN_WIDTH'(in_y) * LIN_WIDTH'(SCREEN_W) + LIN_WIDTH'(in_x);
`ifdef FRAME_WRITER_CLIP_EN
    keep = in_valid & ~(skip_zero & (in_palette == 2'd0)) &
           (in_x < COOR_WIDTH'(SCREEN_W)) & (in_y < COOR_WIDTH'(SCREEN_H));
`else
    keep = in_valid & ~(skip_zero & (in_palette == 2'd0));
`endif
    accept = keep & (state_q == StRun);
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lin_q   <= '0;
      s1_pal_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_lin_q   <= lin;
      s1_pal_q   <= in_palette;
    end
  end

  frame_writer_fb_coalescer u_coalescer (
    .clk         (clk_33m),
    .rst         (rst),
    .pix_valid   (s1_valid_q),
    .pix_lin     (s1_lin_q),
    .pix_pal     (s1_pal_q),
    .force_flush (force_flush),
    .emit_valid  (emit_valid),
    .emit_word   (emit_word)
  );

  always_comb begin
    state_d     = state_q;
    force_flush = 1'b0;
    flush_done  = 1'b0;
    unique case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: if (!s1_valid_q) state_d = StEmit;
      StEmit: begin
        force_flush = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        flush_done = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign busy = (state_q != StRun);

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state_q     <= StRun;
      front_q     <= 1'b0;
      overrun_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q   <= state_d;
      // Sticky protocol-error flag for debug probing only.
      overrun_q <= overrun_q | (in_valid & (state_q != StRun));
      if (state_q == StDone) front_q <= ~front_q;
      mem_we_q  <= emit_valid;
      if (emit_valid) begin
        mem_addr_q  <= {~front_q, emit_word.addr};
        mem_wdata_q <= emit_word.data;
        mem_wmask_q <= emit_word.mask;
      end
    end
  end

  assign front_frame = front_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer: merging, eviction, transparency, last-wins,
// flush latency, clipping (when FRAME_WRITER_CLIP_EN is defined) and reset mid-flush.
module tb_frame_writer;

  logic        clk_33m = 1'b0;
  logic        rst, in_valid, skip_zero, flush_req;
  logic [10:0] in_x, in_y;
  logic [1:0]  in_palette;
  logic        flush_done, busy, front_frame, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic [15:0] wm[$];

  always #5 clk_33m = ~clk_33m;

  frame_writer dut (
    .clk_33m     (clk_33m),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_palette  (in_palette),
    .skip_zero   (skip_zero),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .busy        (busy),
    .front_frame (front_frame),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask)
  );

  always @(posedge clk_33m) cyc <= cyc + 1;

  always @(posedge clk_33m) begin
    #1;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wm.push_back(mem_wmask);
    end
    if (flush_done) done_cnt <= done_cnt + 1;
  end

  task automatic pix(input int x, input int y, input int pal, input bit skip);
    @(negedge clk_33m);
    in_valid   = 1'b1;
    in_x       = 11'(x);
    in_y       = 11'(y);
    in_palette = 2'(pal);
    skip_zero  = skip;
    flush_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_33m);
      in_valid  = 1'b0;
      flush_req = 1'b0;
    end
  endtask

  // Returns cycles from flush_req to flush_done, or -1 on timeout.
  task automatic flush_and_wait(output int lat);
    int t0;
    @(negedge clk_33m);
    in_valid  = 1'b0;
    flush_req = 1'b1;
    t0        = cyc;
    @(negedge clk_33m);
    flush_req = 1'b0;
    lat       = -1;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk_33m);
    end
    @(negedge clk_33m);
  endtask

  task automatic check_one_write(input string name, input int w0, input logic [15:0] ea,
                                 input logic [15:0] em, input logic [31:0] ed);
    n_cmp++;
    if (wa.size() - w0 !== 1) begin
      n_bad++;
      $display("FAIL %s write count: got %0d expected 1", name, wa.size() - w0);
    end
    if (wa.size() > w0) begin
      n_cmp++;
      if (wa[w0] !== ea) begin
        n_bad++;
        $display("FAIL %s addr: got %h expected %h", name, wa[w0], ea);
      end
      n_cmp++;
      if (wm[w0] !== em) begin
        n_bad++;
        $display("FAIL %s wmask: got %h expected %h", name, wm[w0], em);
      end
      n_cmp++;
      if (wd[w0] !== ed) begin
        n_bad++;
        $display("FAIL %s wdata: got %h expected %h", name, wd[w0], ed);
      end
    end
  endtask

  task automatic check_front(input string name, input logic exp);
    n_cmp++;
    if (front_frame !== exp) begin
      n_bad++;
      $display("FAIL %s front_frame: got %b expected %b", name, front_frame, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush_req = 1'b0; skip_zero = 1'b0;
    in_x = '0; in_y = '0; in_palette = '0;
    repeat (3) @(negedge clk_33m);
    n_cmp++;
    if ({mem_we, busy, flush_done, front_frame} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset flags: got %b expected 0000", {mem_we, busy, flush_done, front_frame});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset mem bus: got %h expected 0", {mem_addr, mem_wdata, mem_wmask});
    end
    rst = 1'b0;
    idle(2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset busy after release: got %b expected 0", busy);
    end
  endtask

  task automatic test_full_word;
    int w0, lat;
    w0 = wa.size();
    for (int i = 0; i < 16; i++) pix(i, 0, (i % 3) + 1, 1'b0);
    flush_and_wait(lat);
    check_one_write("full_word", w0, 16'h8000, 16'hFFFF, 32'h79E79E79);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL full_word flush latency: got %0d expected 3", lat);
    end
    check_front("full_word", 1'b1);
  endtask

  task automatic test_adjacent_words;
    int w0, lat;
    w0 = wa.size();
    pix(5, 0, 2, 1'b0);
    pix(0, 1, 3, 1'b0);
    flush_and_wait(lat);
    n_cmp++;
    if (wa.size() - w0 !== 2) begin
      n_bad++;
      $display("FAIL adjacent write count: got %0d expected 2", wa.size() - w0);
    end
    if (wa.size() - w0 >= 2) begin
      n_cmp++;
      if ({wa[w0], wm[w0], wd[w0]} !== {16'd0, 16'h0020, 32'h0000_0800}) begin
        n_bad++;
        $display("FAIL adjacent first write: got %h/%h/%h expected 0000/0020/00000800",
                 wa[w0], wm[w0], wd[w0]);
      end
      n_cmp++;
      if ({wa[w0+1], wm[w0+1], wd[w0+1]} !== {16'd50, 16'h0001, 32'h0000_0003}) begin
        n_bad++;
        $display("FAIL adjacent second write: got %h/%h/%h expected 0032/0001/00000003",
                 wa[w0+1], wm[w0+1], wd[w0+1]);
      end
    end
    check_front("adjacent", 1'b0);
  endtask

  task automatic test_skip_zero;
    int w0, lat;
    w0 = wa.size();
    for (int i = 0; i < 16; i++) pix(i, 0, (i == 3 || i == 7) ? 0 : 3, 1'b1);
    flush_and_wait(lat);
    check_one_write("skip_zero", w0, 16'h8000, 16'hFF77, 32'hFFFF3F3F);
    check_front("skip_zero", 1'b1);
  endtask

  task automatic test_last_wins;
    int w0, lat;
    w0 = wa.size();
    pix(4, 2, 1, 1'b0);
    pix(4, 2, 2, 1'b0);
    flush_and_wait(lat);
    check_one_write("last_wins", w0, 16'd100, 16'h0010, 32'h0000_0200);
    check_front("last_wins", 1'b0);
  endtask

  task automatic test_empty_flush;
    int w0, lat;
    w0 = wa.size();
`ifdef FRAME_WRITER_CLIP_EN
    pix(800, 0, 1, 1'b0);
    pix(0, 480, 2, 1'b0);
`endif
    flush_and_wait(lat);
    n_cmp++;
    if (wa.size() - w0 !== 0) begin
      n_bad++;
      $display("FAIL empty_flush write count: got %0d expected 0", wa.size() - w0);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL empty_flush latency: got %0d expected 3", lat);
    end
    check_front("empty_flush", 1'b1);
  endtask

  task automatic test_reset_mid_flush;
    int w0, d0;
    w0 = wa.size();
    d0 = done_cnt;
    pix(0, 0, 1, 1'b0);
    idle(1);
    @(negedge clk_33m);
    flush_req = 1'b1;
    @(negedge clk_33m);
    flush_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk_33m);
    rst = 1'b0;
    idle(8);
    n_cmp++;
    if (wa.size() - w0 !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_flush writes: got %0d expected 0", wa.size() - w0);
    end
    n_cmp++;
    if (done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_flush flush_done pulses: got %0d expected 0", done_cnt - d0);
    end
    check_front("reset_mid_flush", 1'b0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_flush busy: got %b expected 0", busy);
    end
  endtask

  // Pixel in the flush_req cycle is kept; pixel and flush_req while busy are ignored.
  task automatic test_back_to_back;
    int w0, d0, t0, lat;
    w0 = wa.size();
    d0 = done_cnt;
    @(negedge clk_33m);
    in_valid = 1'b1; in_x = 11'd1; in_y = 11'd0; in_palette = 2'd1; skip_zero = 1'b0;
    flush_req = 1'b1;
    t0 = cyc;
    @(negedge clk_33m);
    in_x = 11'd2; in_palette = 2'd3;
    @(negedge clk_33m);
    in_valid = 1'b0; flush_req = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk_33m);
    end
    idle(5);
    check_one_write("back_to_back", w0, 16'h8000, 16'h0002, 32'h0000_0004);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL back_to_back latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL back_to_back flush_done pulses: got %0d expected 1", done_cnt - d0);
    end
    check_front("back_to_back", 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_adjacent_words();
    test_skip_zero();
    test_last_wins();
    test_empty_flush();
    test_reset_mid_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
